// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_loader_pkg                                          |
// | Purpose  : Shared types and constants for the instruction loader.          |
// |            Defines the loader FSM state encoding and the stream byte       |
// |            width. The CHECK state exists only when                         |
// |            INSTRUCTION_LOADER_CHECKSUM_EN is defined.                      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package instruction_loader_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    CHECK   = 3'd3,
`endif
    DONE    = 3'd4
  } loader_state_t;

endpackage : instruction_loader_pkg
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_loader_if                                           |
// | Purpose  : Bundles the loader control, byte-stream handshake and memory    |
// |            write port.                                                     |
// |            master : load requester / byte source / memory side            |
// |            slave  : the instruction loader itself                         |
// | Signals  : start, base_address, load_words  - load request                 |
// |            in_valid, in_byte, in_ready       - byte stream handshake       |
// |            write_enable/address/data         - memory write port           |
// |            busy, load_done, checksum_error   - status                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface instruction_loader_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  import instruction_loader_pkg::*;

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] base_address;
  logic [ADDRESS_WIDTH:0]   load_words;
  logic                     in_valid;
  logic [BYTE_WIDTH-1:0]    in_byte;
  logic                     in_ready;
  logic                     write_enable;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     busy;
  logic                     load_done;
  logic                     checksum_error;

  modport master (
    output start, base_address, load_words, in_valid, in_byte,
    input  in_ready, write_enable, write_address, write_data,
           busy, load_done, checksum_error
  );

  modport slave (
    input  start, base_address, load_words, in_valid, in_byte,
    output in_ready, write_enable, write_address, write_data,
           busy, load_done, checksum_error
  );

endinterface : instruction_loader_if
`default_nettype wire

// File: rtl/instruction_loader_byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : byte_assembler                                                  |
// | Purpose  : Collects stream bytes into one little-endian word. Byte 0 of a  |
// |            word lands in the least significant lane.                       |
// | Ports    : clk, reset_n      - clock, async active-low reset               |
// |            clear            - restart at lane 0 and zero the word          |
// |            push, data_in    - store data_in in the current lane            |
// |            word             - the (partial) assembled word                 |
// |            word_complete    - this push fills the last lane                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  clear,
  input  wire logic                  push,
  input  wire logic [BYTE_WIDTH-1:0] data_in,
  output logic      [DATA_WIDTH-1:0] word,
  output logic                       word_complete
);

  localparam int c_bytes_per_word = DATA_WIDTH / BYTE_WIDTH;
  localparam int c_index_width    = (c_bytes_per_word > 1) ? $clog2(c_bytes_per_word) : 1;
  localparam logic [c_index_width-1:0] c_last_index = c_index_width'(c_bytes_per_word - 1);

  logic [c_index_width-1:0] r_index;

  // The index wraps explicitly so non-power-of-two lane counts work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index <= '0;
    end else if (clear) begin
      r_index <= '0;
    end else if (push) begin
      r_index <= (r_index == c_last_index) ? '0 : r_index + 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < c_bytes_per_word; g++) begin : g_lane
      logic [BYTE_WIDTH-1:0] r_byte;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_byte <= '0;
        end else if (clear) begin
          r_byte <= '0;
        end else if (push && (r_index == c_index_width'(g))) begin
          r_byte <= data_in;
        end
      end

      assign word[g*BYTE_WIDTH +: BYTE_WIDTH] = r_byte;
    end
  endgenerate

  assign word_complete = push && (r_index == c_last_index);

endmodule : byte_assembler
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_loader                                              |
// | Purpose  : Boot-time instruction memory writer. Takes a byte stream over   |
// |            valid/ready, assembles little-endian words and writes them at   |
// |            sequential (wrapping) addresses starting at base_address.       |
// | Ports    : clk       - clock, rising edge                                  |
// |            reset_n   - asynchronous active-low reset                       |
// |            bus       - instruction_loader_if.slave (request, stream,      |
// |                        memory write port, status)                          |
// | Config   : INSTRUCTION_LOADER_CHECKSUM_EN - when defined, a trailing byte  |
// |            after the last word must make the 8-bit byte sum zero,          |
// |            otherwise checksum_error is raised (sticky until next start).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  instruction_loader_if.slave  bus
);

  loader_state_t            r_state;
  loader_state_t            w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [ADDRESS_WIDTH:0]   r_load_words;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0]    w_word;
  logic                     w_word_complete;
  logic                     w_push;
  logic                     w_clear;
  logic                     w_last_word;
  logic                     w_in_ready;
  logic                     w_write_enable;
  logic                     w_busy;
  logic                     w_load_done;

  // Push is derived from the state register directly (not from w_in_ready)
  // so the assembler feedback into next-state logic stays loop free.
  assign w_push      = bus.in_valid && (r_state == COLLECT);
  assign w_clear     = (r_state == IDLE) && bus.start;
  assign w_last_word = ((r_count + 1'b1) == r_load_words);

  byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_assembler (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (w_clear),
    .push          (w_push),
    .data_in       (bus.in_byte),
    .word          (w_word),
    .word_complete (w_word_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus state-decoded outputs; nothing here reaches an output
  // from an input without passing through r_state.
  always_comb begin
    w_state_next   = r_state;
    w_in_ready     = 1'b0;
    w_write_enable = 1'b0;
    w_busy         = 1'b1;
    w_load_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          if (bus.load_words == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        w_in_ready = 1'b1;
        if (w_word_complete) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_write_enable = 1'b1;
        if (w_last_word) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          w_state_next = CHECK;
`else
          w_state_next = DONE;
`endif
        end else begin
          w_state_next = COLLECT;
        end
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      CHECK: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = DONE;
        end
      end
`endif
      DONE: begin
        w_load_done  = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Load parameters and progress counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_address    <= '0;
      r_load_words <= '0;
      r_count      <= '0;
    end else if (w_clear) begin
      r_address    <= bus.base_address;
      r_load_words <= bus.load_words;
      r_count      <= '0;
    end else if (r_state == WRITE) begin
      // Address wraps silently at the top of memory.
      r_address <= r_address + 1'b1;
      r_count   <= r_count + 1'b1;
    end
  end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] r_sum;
  logic                  r_checksum_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum            <= '0;
      r_checksum_error <= 1'b0;
    end else if (w_clear) begin
      r_sum            <= '0;
      r_checksum_error <= 1'b0;
    end else if (w_push) begin
      r_sum <= r_sum + bus.in_byte;
    end else if ((r_state == CHECK) && bus.in_valid) begin
      // Trailing byte is the two's complement of the data sum when intact.
      r_checksum_error <= ((r_sum + bus.in_byte) != '0);
    end
  end

  assign bus.checksum_error = r_checksum_error;
`else
  assign bus.checksum_error = 1'b0;
`endif

  assign bus.in_ready      = w_in_ready;
  assign bus.write_enable  = w_write_enable;
  assign bus.write_address = r_address;
  assign bus.write_data    = w_word;
  assign bus.busy          = w_busy;
  assign bus.load_done     = w_load_done;

endmodule : instruction_loader
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instruction_loader                                           |
// | Purpose  : Self-checking bench for instruction_loader. Directed table of   |
// |            loads plus hand sequences for reset abort and the checksum     |
// |            option (INSTRUCTION_LOADER_CHECKSUM_EN).                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instruction_loader;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_loader_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();

  instruction_loader #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  words;
    int          nbytes;
    logic [63:0] bytes;      // byte i at [8*i +: 8]
    bit          toggle;     // offer a byte only every other cycle
    int          exp_writes;
    logic [15:0] exp_addr;   // write k address at [8*k +: 8]
    logic [63:0] exp_data;   // write k data at [32*k +: 32]
    int          exp_done;   // cycle of load_done counted from start edge; -1 = not checked
  } vec_t;

  vec_t vec [5];

  task automatic check(input string name, input int vi, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [case %0d]: got 0x%0h, required 0x%0h", name, vi, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {53'd0, bus.in_ready, bus.write_enable, bus.busy, bus.load_done, bus.checksum_error,
            6'd0} ^ {bus.write_data, bus.write_address, 24'd0};
  endfunction

  // Issues start, feeds bytes and records writes until load_done or budget.
  task automatic run_load(input logic [7:0] base, input logic [8:0] words, input int nbytes,
                          input logic [71:0] bytes_in, input bit toggle,
                          output int n_wr, output logic [15:0] wa, output logic [63:0] wd,
                          output int n_done, output int done_cyc, output int bad_ready,
                          output int bad_busy);
    int  idx;
    bit  finished;
    n_wr = 0; wa = '0; wd = '0; n_done = 0; done_cyc = -1;
    bad_ready = 0; bad_busy = 0; idx = 0; finished = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_address = base; bus.load_words = words;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      if (bus.write_enable) begin
        if (n_wr < 2) begin
          wa[8*n_wr +: 8]  = bus.write_address;
          wd[32*n_wr +: 32] = bus.write_data;
        end
        n_wr++;
        if (bus.in_ready) bad_ready++;
      end
      if (!bus.busy) bad_busy++;
      if (bus.load_done) begin
        n_done++;
        done_cyc = cyc;
        finished = 1;
      end
      if (!finished && idx < nbytes && (!toggle || (cyc % 2 == 1))) begin
        bus.in_valid = 1'b1;
        bus.in_byte  = bytes_in[8*idx +: 8];
        if (bus.in_ready) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (!finished) @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n_wr, n_done, done_cyc, bad_ready, bad_busy, nb, exp_done;
    logic [15:0] wa;
    logic [63:0] wd;
    logic [71:0] bytes_ext;
    logic [7:0]  sum;

    vec[0] = '{base:8'h00, words:9'd2, nbytes:8, bytes:64'hDEADBEEF_12345678, toggle:1'b0,
               exp_writes:2, exp_addr:16'h0100, exp_data:64'hDEADBEEF_12345678, exp_done:11};
    vec[1] = '{base:8'h00, words:9'd2, nbytes:8, bytes:64'hDEADBEEF_12345678, toggle:1'b1,
               exp_writes:2, exp_addr:16'h0100, exp_data:64'hDEADBEEF_12345678, exp_done:-1};
    vec[2] = '{base:8'hFF, words:9'd2, nbytes:8, bytes:64'h88776655_44332211, toggle:1'b0,
               exp_writes:2, exp_addr:16'h00FF, exp_data:64'h88776655_44332211, exp_done:11};
    vec[3] = '{base:8'h40, words:9'd0, nbytes:0, bytes:64'h0, toggle:1'b0,
               exp_writes:0, exp_addr:16'h0000, exp_data:64'h0, exp_done:1};
    vec[4] = '{base:8'h10, words:9'd1, nbytes:4, bytes:64'h04030201, toggle:1'b0,
               exp_writes:1, exp_addr:16'h0010, exp_data:64'h04030201, exp_done:6};

    reset_n = 1'b0;
    bus.start = 1'b0; bus.base_address = '0; bus.load_words = '0;
    bus.in_valid = 1'b0; bus.in_byte = '0;
    #1;
    check("reset_outputs", -1, out_vec(), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", -1, out_vec(), 64'h0);

    // Table-driven loads.
    for (int v = 0; v < 5; v++) begin
      bytes_ext = {8'h00, vec[v].bytes};
      nb        = vec[v].nbytes;
      exp_done  = vec[v].exp_done;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      if (vec[v].words != 0) begin
        sum = 8'h00;
        for (int b = 0; b < vec[v].nbytes; b++) sum = sum + bytes_ext[8*b +: 8];
        bytes_ext[8*nb +: 8] = 8'h00 - sum;
        nb = nb + 1;
        if (exp_done >= 0) exp_done = exp_done + 1;
      end
`endif
      run_load(vec[v].base, vec[v].words, nb, bytes_ext, vec[v].toggle,
               n_wr, wa, wd, n_done, done_cyc, bad_ready, bad_busy);
      check("write_count", v, 64'(n_wr), 64'(vec[v].exp_writes));
      check("write_addr", v, 64'(wa), 64'(vec[v].exp_addr));
      check("write_data", v, wd, vec[v].exp_data);
      check("done_pulses", v, 64'(n_done), 64'd1);
      if (exp_done >= 0) check("done_cycle", v, 64'(done_cyc), 64'(exp_done));
      check("ready_in_write", v, 64'(bad_ready), 64'd0);
      check("busy_during_load", v, 64'(bad_busy), 64'd0);
      @(negedge clk);
      check("after_done", v, {61'd0, bus.busy, bus.load_done, bus.checksum_error}, 64'h0);
    end

    // Reset in the middle of a word: two of four bytes accepted, then abort.
    @(negedge clk);
    bus.start = 1'b1; bus.base_address = 8'h20; bus.load_words = 9'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_byte = 8'hAA;
    @(negedge clk);
    bus.in_byte = 8'hBB;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_load_busy_no_we", 5, {62'd0, bus.busy, bus.write_enable}, 64'h2);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", 5, out_vec(), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bytes_ext = 72'h0;
    bytes_ext[31:0] = 32'hA4A3A2A1;
    nb = 4;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    bytes_ext[39:32] = 8'h00 - 8'hA1 - 8'hA2 - 8'hA3 - 8'hA4;
    nb = 5;
`endif
    run_load(8'h20, 9'd1, nb, bytes_ext, 1'b0, n_wr, wa, wd, n_done, done_cyc, bad_ready, bad_busy);
    check("reload_count", 5, 64'(n_wr), 64'd1);
    check("reload_addr", 5, 64'(wa), 64'h20);
    check("reload_data", 5, wd, 64'hA4A3A2A1);
    check("reload_done", 5, 64'(n_done), 64'd1);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // Good trailing byte.
    run_load(8'h30, 9'd1, 5, 72'hF6_04030201, 1'b0, n_wr, wa, wd, n_done, done_cyc, bad_ready, bad_busy);
    check("cks_good_data", 6, wd, 64'h04030201);
    check("cks_good_err", 6, 64'(bus.checksum_error), 64'd0);
    // Bad trailing byte: error must stick through idle cycles.
    run_load(8'h30, 9'd1, 5, 72'hF7_04030201, 1'b0, n_wr, wa, wd, n_done, done_cyc, bad_ready, bad_busy);
    check("cks_bad_err", 7, 64'(bus.checksum_error), 64'd1);
    repeat (3) @(negedge clk);
    check("cks_bad_sticky", 7, 64'(bus.checksum_error), 64'd1);
    run_load(8'h00, 9'd0, 0, 72'h0, 1'b0, n_wr, wa, wd, n_done, done_cyc, bad_ready, bad_busy);
    check("cks_cleared_by_start", 7, 64'(bus.checksum_error), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_instruction_loader
`default_nettype wire
